// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, FSM state type and digit legality check
package bcd_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_mac10.sv
// bcd_mac10: combinational o_acc = i_acc*10 + i_d, truncated to WIDTH bits
//   i_acc [WIDTH-1:0] running value
//   i_d   [3:0]       digit to append
//   o_acc [WIDTH-1:0] i_acc*10 + i_d
module bcd_mac10 #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [3:0]       i_d,
  output logic [WIDTH-1:0] o_acc
);
  assign o_acc = (i_acc << 3) + (i_acc << 1) + WIDTH'(i_d);
endmodule

// File: rtl/bcd_digit_to_bin.sv
// bcd_digit_to_bin: accumulates MSD-first BCD digits into a binary value on a valid/ready port
//   i_clk, i_rst (sync, active-low)
//   i_digit_in/i_digit_valid/i_digit_last, o_digit_ready : digit input handshake
//   o_bin_out/o_bin_ndig/o_bin_err/o_bin_ovf, o_bin_valid, i_bin_ready : result handshake
module bcd_digit_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int WIDTH  = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [3:0]       i_digit_in,
  input  logic             i_digit_valid,
  input  logic             i_digit_last,
  output logic             o_digit_ready,
  output logic [WIDTH-1:0] o_bin_out,
  output logic [2:0]       o_bin_ndig,
  output logic             o_bin_err,
  output logic             o_bin_ovf,
  output logic             o_bin_valid,
  input  logic             i_bin_ready
);
  localparam logic [2:0] MAXN = 3'(DIGITS);
  state_t           r_state, w_next;
  logic             r_rdy, r_err, r_ovf;
  logic [WIDTH-1:0] r_acc, w_mac;
  logic [2:0]       r_count;
  logic             w_xfer, w_legal, w_done, w_take;
  assign w_done  = r_state == DONE;
  assign w_take  = w_done & i_bin_ready;
  assign w_xfer  = i_digit_valid & r_rdy;
  assign w_legal = is_bcd(i_digit_in);
  // acc is zero whenever IDLE, so the first digit uses the same MAC path
  bcd_mac10 #(.WIDTH(WIDTH)) u_mac (
    .i_acc(r_acc),
    .i_d  (w_legal ? i_digit_in : 4'd0),
    .o_acc(w_mac)
  );
  always_ff @(posedge i_clk)
    r_state <= !i_rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (w_done) w_next = i_bin_ready ? IDLE : DONE;
    else if (w_xfer) w_next = i_digit_last ? DONE : ACCUM;
  end
  always_comb begin
    o_digit_ready = r_rdy;
    o_bin_valid   = w_done;
    o_bin_out     = w_done ? r_acc : '0;
    o_bin_ndig    = w_done ? r_count : 3'd0;
    o_bin_err     = w_done & r_err;
    o_bin_ovf     = w_done & r_ovf;
  end
  // registered from next state: low through reset and DONE, rises one edge after either
  always_ff @(posedge i_clk)
    r_rdy <= i_rst && (w_next != DONE);
  always_ff @(posedge i_clk) begin
    if (!i_rst || w_take) begin
      r_acc   <= '0;
      r_count <= 3'd0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_xfer) begin
      r_err <= r_err | ~w_legal;
      if (r_count < MAXN) begin
        r_acc   <= w_mac;
        r_count <= r_count + 3'd1;
      end else begin
        r_ovf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bcd_digit_to_bin.sv
// tb_bcd_digit_to_bin: directed and randomized checks against a digit-list reference model
module tb_bcd_digit_to_bin;
  localparam int DIGITS = 2;
  localparam int WIDTH  = 7;
  typedef struct {int val; int ndig; bit err; bit ovf;} res_t;
  logic             clk = 0, rst = 0;
  logic [3:0]       digit_in = 0;
  logic             digit_valid = 0, digit_last = 0, bin_ready = 1;
  logic             digit_ready, bin_err, bin_ovf, bin_valid;
  logic [WIDTH-1:0] bin_out;
  logic [2:0]       bin_ndig;
  int               errors = 0, checks = 0;
  res_t             q[$];
  int               cur[$];
  bit               armed = 0, last_rst = 0, rnd = 0;
  always #5 clk = ~clk;
  bcd_digit_to_bin #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_digit_in(digit_in), .i_digit_valid(digit_valid),
    .i_digit_last(digit_last), .o_digit_ready(digit_ready), .o_bin_out(bin_out),
    .o_bin_ndig(bin_ndig), .o_bin_err(bin_err), .o_bin_ovf(bin_ovf),
    .o_bin_valid(bin_valid), .i_bin_ready(bin_ready)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  // value = sum of kept digits weighted by powers of ten; illegal digits weigh as zero
  function automatic res_t model(input int ds[$]);
    res_t r;
    int n;
    r = '{0, 0, 0, 0};
    n = ds.size() < DIGITS ? ds.size() : DIGITS;
    for (int i = 0; i < n; i++) r.val += (ds[i] > 9 ? 0 : ds[i]) * 10 ** (n - 1 - i);
    r.val  = r.val % (1 << WIDTH);
    r.ndig = n;
    r.ovf  = ds.size() > DIGITS;
    foreach (ds[i]) if (ds[i] > 9) r.err = 1;
    return r;
  endfunction
  initial forever begin
    @(negedge clk);
    if (armed) begin
      if (!last_rst) begin
        chk("rst_valid", bin_valid, 0);
        chk("rst_ready", digit_ready, 0);
        chk("rst_out", bin_out, 0);
        chk("rst_ndig", bin_ndig, 0);
        chk("rst_err", bin_err, 0);
        chk("rst_ovf", bin_ovf, 0);
      end else begin
        chk("valid", bin_valid, q.size() > 0);
        chk("digit_ready", digit_ready, q.size() == 0);
        if (q.size() > 0) begin
          chk("bin_out", bin_out, q[0].val);
          chk("bin_ndig", bin_ndig, q[0].ndig);
          chk("bin_err", bin_err, q[0].err);
          chk("bin_ovf", bin_ovf, q[0].ovf);
        end
      end
    end
    if (!rst) begin
      cur.delete();
      q.delete();
    end else if (armed && last_rst) begin
      if (q.size() > 0) begin
        if (bin_ready) void'(q.pop_front());
      end else if (digit_valid) begin
        cur.push_back(int'(digit_in));
        if (digit_last) begin
          q.push_back(model(cur));
          cur.delete();
        end
      end
    end
    if (!rst) armed = 1;
    last_rst = rst;
  end
  task automatic send(input logic [3:0] d, input bit l);
    int k = 0;
    digit_in = d;
    digit_last = l;
    digit_valid = 1;
    @(negedge clk);
    while (!digit_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!digit_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: digit_ready=%0d expected 1", digit_ready);
    end
    @(posedge clk);
    #1 digit_valid = 0;
    digit_last = 0;
  endtask
  task automatic get_result(output res_t r);
    int k = 0;
    @(negedge clk);
    while (!bin_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bin_valid) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: bin_valid=%0d expected 1", bin_valid);
    end
    r = '{int'(bin_out), int'(bin_ndig), bin_err, bin_ovf};
    @(posedge clk);
    #1;
  endtask
  task automatic expect_res(input string name, input int v, input int n, input bit e, input bit o);
    res_t r;
    get_result(r);
    chk({name, "_out"}, r.val, v);
    chk({name, "_ndig"}, r.ndig, n);
    chk({name, "_err"}, r.err, e);
    chk({name, "_ovf"}, r.ovf, o);
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] d;
    int len;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ready", digit_ready, 0);
    chk("reset_valid", bin_valid, 0);
    chk("reset_out", bin_out, 0);
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("release_ready_low", digit_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("release_ready_high", digit_ready, 1);
    @(posedge clk);
    #1;
    send(4, 0);
    send(2, 1);
    expect_res("r42", 42, 2, 0, 0);
    bin_ready = 0;
    send(7, 1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_out", bin_out, 7);
      chk("hold_valid", bin_valid, 1);
      chk("hold_ready", digit_ready, 0);
      @(posedge clk);
      #1;
    end
    bin_ready = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("after_take_valid", bin_valid, 0);
    chk("after_take_ready", digit_ready, 1);
    @(posedge clk);
    #1;
    send(9, 0);
    send(9, 1);
    expect_res("r99", 99, 2, 0, 0);
    send(1, 0);
    send(5, 1);
    expect_res("r15", 15, 2, 0, 0);
    send(1, 0);
    send(4'hB, 1);
    expect_res("r10err", 10, 2, 1, 0);
    send(3, 1);
    expect_res("r3", 3, 1, 0, 0);
    send(1, 0);
    send(2, 0);
    send(3, 1);
    expect_res("r12ovf", 12, 2, 0, 1);
    send(5, 0);
    rst = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1;
    send(8, 1);
    expect_res("r8", 8, 1, 0, 0);
    rnd = 1;
    fork
      while (rnd) begin
        @(posedge clk);
        #1 bin_ready = $urandom_range(0, 2) != 0;
      end
    join_none
    for (int n = 0; n < 200; n++) begin
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
        d = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        send(d, j == len - 1);
        if ($urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 3)) begin
            @(posedge clk);
            #1;
          end
        if ($urandom_range(0, 49) == 0) begin
          rst = 0;
          repeat (2) begin
            @(posedge clk);
            #1;
          end
          rst = 1;
        end
      end
    end
    rnd = 0;
    @(posedge clk);
    #1 bin_ready = 1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("final_idle_valid", bin_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
